wb_tag_reg_bridge: RTL and testbench
====================================

WB_TAG_REG_BRIDGE -- requirements
Module: wb_tag_reg_bridge

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- ADR_WIDTH, 32, address width
- DAT_WIDTH, 32, data width (multiple of 8)
- TGA_WIDTH, 4, address tag width
- TGD_WIDTH, 4, data tag width
- TGC_WIDTH, 4, cycle tag width
- TIMEOUT, 255, FWD cycles before error (0 = disabled)
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low reset
- t_adr/t_dat_w/t_sel/t_we/t_cyc/t_stb  in  ADR_WIDTH/DAT_WIDTH/DAT_WIDTH/8/1/1/1  upstream request
- t_tga/t_tgd_w/t_tgc  in  TGA_WIDTH/TGD_WIDTH/TGC_WIDTH  upstream request tags
- t_dat_r/t_tgd_r/t_ack/t_err  out  DAT_WIDTH/TGD_WIDTH/1/1  upstream response
- i_adr/i_dat_w/i_sel/i_we/i_cyc/i_stb  out  as t_ equivalents  request to interconnect target port
- i_tga/i_tgd_w/i_tgc  out  as t_ equivalents  request tags
- i_dat_r/i_tgd_r/i_ack/i_err  in  DAT_WIDTH/TGD_WIDTH/1/1  response from interconnect
- timeout  out  1  one-cycle pulse on timeout
REQ-003 Every output SHALL be driven from flops or from the state register only; no combinational path from any t_ input to any i_ output, or from any i_ input to any t_ output.

Function
REQ-004 FSM SHALL have states IDLE, FWD, RSP.
REQ-005 IDLE: on t_cyc && t_stb, capture t_adr, t_dat_w, t_sel, t_we, t_tga, t_tgd_w and t_tgc; clear the timeout counter; go to FWD. Otherwise stay in IDLE.
REQ-006 In IDLE, i_cyc = i_stb = 0. i_ack and i_err SHALL be ignored.
REQ-007 In FWD, i_cyc = i_stb = 1 and all i_ request outputs SHALL equal the captured values, held stable until the state exits.
REQ-008 FWD exits on i_ack || i_err:
- capture i_dat_r, i_tgd_r and err_flag = i_err
- i_err && i_ack in the same cycle: err_flag = 1
- go to RSP
REQ-009 Timeout counter behaviour:
- increments each FWD cycle with no i_ack/i_err
- when TIMEOUT != 0 and the counter reaches TIMEOUT, the next state is RSP with err_flag = 1, captured dat_r = 0, tgd_r = 0, and timeout pulsed high for exactly that transition cycle
- i_ack/i_err arriving in the expiry cycle takes priority (normal completion, no timeout pulse)
REQ-010 Counter width SHALL be $clog2(TIMEOUT+1). The counter SHALL saturate and never wrap.
REQ-011 RSP SHALL last exactly one cycle:
- t_ack = !err_flag and t_err = err_flag
- t_dat_r/t_tgd_r = captured values
- i_cyc = i_stb = 0
- next state IDLE
REQ-012 t_ack and t_err SHALL be 0 in IDLE and FWD, and SHALL never both be 1.
REQ-013 Abort: if t_cyc is 0 in any FWD cycle, set the abort flag.
- The downstream cycle continues until completion or timeout.
- RSP then asserts neither t_ack nor t_err; the timeout pulse still fires if applicable.
REQ-014 Latency:
- request sampled in IDLE at edge N gives i_stb = 1 in cycle N+1
- i_ack sampled at edge M gives t_ack = 1 in cycle M+1
- minimum upstream transaction is 3 cycles; back-to-back throughput is 1 transfer per 3 cycles
REQ-015 In RSP, the upstream t_stb SHALL NOT be sampled. A new request is accepted only in IDLE, which gives one mandatory dead cycle after each response.
REQ-016 t_dat_r/t_tgd_r SHALL hold their last captured values outside RSP. They are only valid while t_ack = 1.

Reset
REQ-017 With reset == 0 at a clock edge:
- state = IDLE
- i_cyc = i_stb = i_we = 0
- t_ack = t_err = 0, timeout = 0
- counter = 0, err_flag = 0, abort flag = 0
- all captured request and response registers = 0
REQ-018 Reset asserted in FWD SHALL drop i_cyc/i_stb on the next edge, with no upstream response. A late i_ack after reset SHALL be ignored.

Verification
REQ-019 Write: t_adr = 'h2800_0010, t_dat_w = 'hDEAD_BEEF, t_we = 1, t_sel = 'hF, t_tga = 3. Required:
- i_stb = 1 one cycle later with identical i_ fields
- i_ack driven 2 cycles later
- t_ack = 1 for exactly one cycle after that
REQ-020 Read: i_dat_r = 'h1234_5678, i_tgd_r = 5 returned with i_ack. Required: t_dat_r = 'h1234_5678, t_tgd_r = 5, t_ack = 1 the next cycle.
REQ-021 Error: i_ack = i_err = 1 in the same cycle. Required: t_err = 1, t_ack = 0 for one cycle.
REQ-022 Timeout: TIMEOUT = 4, downstream never acks. Required:
- i_stb stays high for 5 cycles
- timeout pulses once
- t_err = 1 with t_dat_r = 0
- i_cyc = 0 in the RSP cycle
REQ-023 Abort: t_cyc dropped in the second FWD cycle, i_ack 3 cycles later. Required: i_stb held until i_ack; no t_ack/t_err pulse; state returns to IDLE.
REQ-024 Reset mid-FWD: reset = 0 for 1 cycle while i_stb = 1. Required: i_cyc = i_stb = 0 next cycle; a subsequent i_ack produces no t_ack.

Source files
------------

// File: rtl/wb_tag_reg_bridge.sv
// Registered Wishbone bridge with address/data/cycle tags: one outstanding transfer,
// IDLE -> FWD -> RSP, downstream timeout and upstream abort handling.
module wb_tag_reg_bridge #(
   parameter int ADR_WIDTH = 32,
   parameter int DAT_WIDTH = 32,
   parameter int TGA_WIDTH = 4,
   parameter int TGD_WIDTH = 4,
   parameter int TGC_WIDTH = 4,
   parameter int TIMEOUT   = 255
) (
   input  logic                   clock,
   input  logic                   reset,
   // upstream request
   input  logic [ADR_WIDTH-1:0]   t_adr,
   input  logic [DAT_WIDTH-1:0]   t_dat_w,
   input  logic [DAT_WIDTH/8-1:0] t_sel,
   input  logic                   t_we,
   input  logic                   t_cyc,
   input  logic                   t_stb,
   input  logic [TGA_WIDTH-1:0]   t_tga,
   input  logic [TGD_WIDTH-1:0]   t_tgd_w,
   input  logic [TGC_WIDTH-1:0]   t_tgc,
   // upstream response
   output logic [DAT_WIDTH-1:0]   t_dat_r,
   output logic [TGD_WIDTH-1:0]   t_tgd_r,
   output logic                   t_ack,
   output logic                   t_err,
   // downstream request
   output logic [ADR_WIDTH-1:0]   i_adr,
   output logic [DAT_WIDTH-1:0]   i_dat_w,
   output logic [DAT_WIDTH/8-1:0] i_sel,
   output logic                   i_we,
   output logic                   i_cyc,
   output logic                   i_stb,
   output logic [TGA_WIDTH-1:0]   i_tga,
   output logic [TGD_WIDTH-1:0]   i_tgd_w,
   output logic [TGC_WIDTH-1:0]   i_tgc,
   // downstream response
   input  logic [DAT_WIDTH-1:0]   i_dat_r,
   input  logic [TGD_WIDTH-1:0]   i_tgd_r,
   input  logic                   i_ack,
   input  logic                   i_err,
   output logic                   timeout
);

   localparam int SEL_WIDTH = DAT_WIDTH / 8;
   // Keep the counter at least one bit wide so TIMEOUT = 0 still elaborates.
   localparam int CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] CNT_SAT   = '1;

   typedef enum logic [1:0] {IDLE, FWD, RSP} state_t;

   typedef struct packed {
      logic [ADR_WIDTH-1:0] adr;
      logic [DAT_WIDTH-1:0] dat;
      logic [SEL_WIDTH-1:0] sel;
      logic                 we;
      logic [TGA_WIDTH-1:0] tga;
      logic [TGD_WIDTH-1:0] tgd;
      logic [TGC_WIDTH-1:0] tgc;
   } req_t;

   typedef struct packed {
      logic [DAT_WIDTH-1:0] dat;
      logic [TGD_WIDTH-1:0] tgd;
   } rsp_t;

   state_t               state_q, state_d;
   req_t                 req_q, req_d;
   rsp_t                 rsp_q, rsp_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 err_q, err_d;
   logic                 abort_q, abort_d;
   logic                 timeout_q, timeout_d;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= IDLE;
         req_q     <= '0;
         rsp_q     <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         abort_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         rsp_q     <= rsp_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         abort_q   <= abort_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      rsp_d     = rsp_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      abort_d   = abort_q;
      timeout_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (t_cyc && t_stb) begin
               req_d.adr = t_adr;
               req_d.dat = t_dat_w;
               req_d.sel = t_sel;
               req_d.we  = t_we;
               req_d.tga = t_tga;
               req_d.tgd = t_tgd_w;
               req_d.tgc = t_tgc;
               cnt_d     = '0;
               err_d     = 1'b0;
               abort_d   = 1'b0;
               state_d   = FWD;
            end
         end
         FWD: begin
            // A dropped upstream cycle only suppresses the response; the
            // downstream transfer is still run to completion.
            if (!t_cyc) abort_d = 1'b1;
            if (i_ack || i_err) begin
               rsp_d.dat = i_dat_r;
               rsp_d.tgd = i_tgd_r;
               err_d     = i_err;
               state_d   = RSP;
            end else if (TIMEOUT != 0 && cnt_q == CNT_LIMIT) begin
               rsp_d     = '0;
               err_d     = 1'b1;
               timeout_d = 1'b1;
               state_d   = RSP;
            end else if (cnt_q != CNT_SAT) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RSP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign i_adr   = req_q.adr;
   assign i_dat_w = req_q.dat;
   assign i_sel   = req_q.sel;
   assign i_we    = req_q.we;
   assign i_tga   = req_q.tga;
   assign i_tgd_w = req_q.tgd;
   assign i_tgc   = req_q.tgc;
   assign i_cyc   = (state_q == FWD);
   assign i_stb   = (state_q == FWD);

   assign t_dat_r = rsp_q.dat;
   assign t_tgd_r = rsp_q.tgd;
   assign t_ack   = (state_q == RSP) && !err_q && !abort_q;
   assign t_err   = (state_q == RSP) &&  err_q && !abort_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_wb_tag_reg_bridge.sv
// Directed bench for wb_tag_reg_bridge built with TIMEOUT = 4; all activity
// happens 1 time unit after each rising edge.
module tb_wb_tag_reg_bridge;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] t_adr = '0, t_dat_w = '0, t_dat_r;
   logic [3:0]  t_sel = '0, t_tga = '0, t_tgd_w = '0, t_tgc = '0, t_tgd_r;
   logic        t_we = 0, t_cyc = 0, t_stb = 0, t_ack, t_err;
   logic [31:0] i_adr, i_dat_w, i_dat_r = '0;
   logic [3:0]  i_sel, i_tga, i_tgd_w, i_tgc, i_tgd_r = '0;
   logic        i_we, i_cyc, i_stb, i_ack = 0, i_err = 0, timeout;

   int checks = 0;
   int failures = 0;

   wb_tag_reg_bridge #(.TIMEOUT(4)) dut (
      .clock(clock), .reset(reset),
      .t_adr(t_adr), .t_dat_w(t_dat_w), .t_sel(t_sel), .t_we(t_we),
      .t_cyc(t_cyc), .t_stb(t_stb), .t_tga(t_tga), .t_tgd_w(t_tgd_w), .t_tgc(t_tgc),
      .t_dat_r(t_dat_r), .t_tgd_r(t_tgd_r), .t_ack(t_ack), .t_err(t_err),
      .i_adr(i_adr), .i_dat_w(i_dat_w), .i_sel(i_sel), .i_we(i_we),
      .i_cyc(i_cyc), .i_stb(i_stb), .i_tga(i_tga), .i_tgd_w(i_tgd_w), .i_tgc(i_tgc),
      .i_dat_r(i_dat_r), .i_tgd_r(i_tgd_r), .i_ack(i_ack), .i_err(i_err),
      .timeout(timeout)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                        input logic [3:0] tga);
      t_adr = adr; t_dat_w = dat; t_we = we; t_sel = 4'hF; t_tga = tga;
      t_tgd_w = 4'h9; t_tgc = 4'h6; t_cyc = 1; t_stb = 1;
      step();
      t_stb = 0;
   endtask

   task automatic test_reset();
      t_adr = 32'hFFFF_FFFF; t_cyc = 1; t_stb = 1; i_ack = 1; i_err = 1;
      reset = 0;
      step(); step();
      checks++; if ({i_cyc, i_stb, i_we} !== 3'b000) begin failures++; $display("FAIL rst_i got=%b exp=000", {i_cyc, i_stb, i_we}); end
      checks++; if ({t_ack, t_err, timeout} !== 3'b000) begin failures++; $display("FAIL rst_t got=%b exp=000", {t_ack, t_err, timeout}); end
      checks++; if (i_adr !== 32'h0 || t_dat_r !== 32'h0 || t_tgd_r !== 4'h0) begin failures++; $display("FAIL rst_regs adr=%h dat_r=%h tgd_r=%h exp=0", i_adr, t_dat_r, t_tgd_r); end
      t_cyc = 0; t_stb = 0; i_ack = 0; i_err = 0; t_adr = '0;
      reset = 1;
      step();
   endtask

   task automatic test_write();
      issue(32'h2800_0010, 32'hDEAD_BEEF, 1'b1, 4'h3);
      checks++; if ({i_cyc, i_stb} !== 2'b11) begin failures++; $display("FAIL wr_stb got=%b exp=11", {i_cyc, i_stb}); end
      checks++; if (i_adr !== 32'h2800_0010 || i_dat_w !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_fields adr=%h dat=%h exp=28000010/deadbeef", i_adr, i_dat_w); end
      checks++; if ({i_we, i_sel, i_tga, i_tgd_w, i_tgc} !== {1'b1, 4'hF, 4'h3, 4'h9, 4'h6}) begin failures++; $display("FAIL wr_tags got=%h exp=%h", {i_we, i_sel, i_tga, i_tgd_w, i_tgc}, {1'b1, 4'hF, 4'h3, 4'h9, 4'h6}); end
      step();
      checks++; if (i_stb !== 1'b1 || i_adr !== 32'h2800_0010 || t_ack !== 1'b0) begin failures++; $display("FAIL wr_hold stb=%b adr=%h ack=%b exp=1/28000010/0", i_stb, i_adr, t_ack); end
      i_ack = 1;
      step();
      i_ack = 0; t_cyc = 0;
      checks++; if ({t_ack, t_err, i_cyc, i_stb} !== 4'b1000) begin failures++; $display("FAIL wr_rsp ack/err/cyc/stb got=%b exp=1000", {t_ack, t_err, i_cyc, i_stb}); end
      step();
      checks++; if (t_ack !== 1'b0) begin failures++; $display("FAIL wr_ack_once got=%b exp=0", t_ack); end
   endtask

   task automatic test_read();
      issue(32'h0000_0400, 32'h0, 1'b0, 4'h1);
      i_ack = 1; i_dat_r = 32'h1234_5678; i_tgd_r = 4'h5;
      step();
      i_ack = 0; i_dat_r = 32'h0; i_tgd_r = 4'h0; t_cyc = 0;
      checks++; if (t_ack !== 1'b1 || t_dat_r !== 32'h1234_5678 || t_tgd_r !== 4'h5) begin failures++; $display("FAIL rd_rsp ack=%b dat=%h tgd=%h exp=1/12345678/5", t_ack, t_dat_r, t_tgd_r); end
      step();
      checks++; if (t_ack !== 1'b0 || t_dat_r !== 32'h1234_5678 || t_tgd_r !== 4'h5) begin failures++; $display("FAIL rd_hold ack=%b dat=%h tgd=%h exp=0/12345678/5", t_ack, t_dat_r, t_tgd_r); end
      // stray downstream ack while idle must not produce anything
      i_ack = 1;
      step();
      i_ack = 0;
      checks++; if ({i_stb, t_ack, t_err} !== 3'b000) begin failures++; $display("FAIL idle_ack got=%b exp=000", {i_stb, t_ack, t_err}); end
   endtask

   task automatic test_error();
      issue(32'h0000_0800, 32'h0, 1'b0, 4'h2);
      i_ack = 1; i_err = 1; i_dat_r = 32'hCAFE_0001;
      step();
      i_ack = 0; i_err = 0; t_cyc = 0;
      checks++; if ({t_err, t_ack} !== 2'b10) begin failures++; $display("FAIL err_rsp err/ack got=%b exp=10", {t_err, t_ack}); end
      step();
      checks++; if ({t_err, t_ack} !== 2'b00) begin failures++; $display("FAIL err_once err/ack got=%b exp=00", {t_err, t_ack}); end
   endtask

   task automatic test_timeout();
      int stb_cycles = 0;
      int pulses = 0;
      issue(32'h0000_0C00, 32'h0, 1'b0, 4'h4);
      for (int k = 0; k < 12; k++) begin
         if (!i_stb) break;
         stb_cycles++;
         if (timeout) pulses++;
         step();
      end
      if (timeout) pulses++;
      checks++; if (stb_cycles !== 5) begin failures++; $display("FAIL to_stb_cycles got=%0d exp=5", stb_cycles); end
      checks++; if ({t_err, t_ack, i_cyc, timeout} !== 4'b1001) begin failures++; $display("FAIL to_rsp err/ack/cyc/timeout got=%b exp=1001", {t_err, t_ack, i_cyc, timeout}); end
      checks++; if (t_dat_r !== 32'h0 || t_tgd_r !== 4'h0) begin failures++; $display("FAIL to_data dat=%h tgd=%h exp=0", t_dat_r, t_tgd_r); end
      t_cyc = 0;
      step();
      if (timeout) pulses++;
      checks++; if (pulses !== 1) begin failures++; $display("FAIL to_pulses got=%0d exp=1", pulses); end
   endtask

   task automatic test_expiry_ack();
      issue(32'h0000_1000, 32'h0, 1'b0, 4'h5);
      step(); step(); step(); step();
      checks++; if (i_stb !== 1'b1) begin failures++; $display("FAIL exp_stb got=%b exp=1", i_stb); end
      i_ack = 1; i_dat_r = 32'hA5A5_A5A5;
      step();
      i_ack = 0; t_cyc = 0;
      checks++; if ({t_ack, t_err, timeout} !== 3'b100 || t_dat_r !== 32'hA5A5_A5A5) begin failures++; $display("FAIL exp_prio ack/err/to=%b dat=%h exp=100/a5a5a5a5", {t_ack, t_err, timeout}, t_dat_r); end
      step();
   endtask

   task automatic test_abort();
      int stb_cycles = 1;
      int rsp_seen = 0;
      issue(32'h0000_1400, 32'h0, 1'b1, 4'h6);
      step();
      t_cyc = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         if (i_stb) stb_cycles++;
         if (t_ack || t_err) rsp_seen++;
      end
      i_ack = 1;
      step();
      i_ack = 0;
      checks++; if (stb_cycles !== 4) begin failures++; $display("FAIL ab_stb_held got=%0d exp=4", stb_cycles); end
      checks++; if ({t_ack, t_err, timeout, i_stb} !== 4'b0000) begin failures++; $display("FAIL ab_rsp ack/err/to/stb got=%b exp=0000", {t_ack, t_err, timeout, i_stb}); end
      step();
      if (t_ack || t_err) rsp_seen++;
      checks++; if (rsp_seen !== 0) begin failures++; $display("FAIL ab_no_rsp got=%0d exp=0", rsp_seen); end
      // bridge is back in IDLE and accepts a fresh request
      issue(32'h0000_1800, 32'h0, 1'b0, 4'h7);
      checks++; if (i_stb !== 1'b1 || i_adr !== 32'h0000_1800) begin failures++; $display("FAIL ab_idle stb=%b adr=%h exp=1/00001800", i_stb, i_adr); end
      i_ack = 1;
      step();
      i_ack = 0; t_cyc = 0;
      checks++; if (t_ack !== 1'b1) begin failures++; $display("FAIL ab_next_ack got=%b exp=1", t_ack); end
      step();
   endtask

   task automatic test_reset_fwd();
      issue(32'h0000_1C00, 32'h0, 1'b1, 4'h8);
      checks++; if (i_stb !== 1'b1) begin failures++; $display("FAIL rf_stb got=%b exp=1", i_stb); end
      reset = 0;
      step();
      reset = 1;
      checks++; if ({i_cyc, i_stb} !== 2'b00) begin failures++; $display("FAIL rf_drop got=%b exp=00", {i_cyc, i_stb}); end
      t_cyc = 0;
      i_ack = 1;
      step();
      i_ack = 0;
      checks++; if ({t_ack, t_err} !== 2'b00) begin failures++; $display("FAIL rf_late_ack got=%b exp=00", {t_ack, t_err}); end
      step();
      checks++; if ({t_ack, t_err, i_stb} !== 3'b000) begin failures++; $display("FAIL rf_quiet got=%b exp=000", {t_ack, t_err, i_stb}); end
   endtask

   task automatic test_back_to_back();
      logic [8:0] stb_seen, ack_seen;
      logic [8:0] stb_exp, ack_exp;
      stb_exp = 9'b100100100;
      ack_exp = 9'b010010010;
      t_adr = 32'h0000_2000; t_cyc = 1; t_stb = 1; i_ack = 1;
      for (int k = 8; k >= 0; k--) begin
         step();
         stb_seen[k] = i_stb;
         ack_seen[k] = t_ack;
      end
      t_cyc = 0; t_stb = 0; i_ack = 0;
      checks++; if (stb_seen !== stb_exp) begin failures++; $display("FAIL b2b_stb got=%b exp=%b", stb_seen, stb_exp); end
      checks++; if (ack_seen !== ack_exp) begin failures++; $display("FAIL b2b_ack got=%b exp=%b", ack_seen, ack_exp); end
      step(); step();
   endtask

   initial begin
      #1;
      test_reset();
      test_write();
      test_read();
      test_error();
      test_timeout();
      test_expiry_ack();
      test_abort();
      test_reset_fwd();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule
